clock_period_meter: RTL

- Measures an external slow clock or periodic signal against the system clock. It reports the period and high time in system-clock cycles.
- It is the receiving-side counterpart of the clock dividers. It checks and monitors divided or off-chip clocks, for example a 10 MHz divider output sampled at 100 MHz.
- It raises a timeout flag when the measured signal stops toggling.

---
 rtl/clock_period_meter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_period_meter
//  Description : Measures the period and high time of an asynchronous slow
//                clock / periodic signal in system-clock cycles, with a
//                sticky timeout flag when the signal stops toggling.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_signal,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   sync_bit;
  logic                   primed;
  logic                   rise;
  logic                   fall;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       fall_cap;

  assign sync_bit    = sync_chain[SYNC_STAGES-1];
  // The chain is cleared by reset, so its output only reflects i_signal once
  // every stage has been refilled; until then a "low" is not trustworthy and
  // must not be allowed to arm the meter (signal already high at reset).
  assign primed      = fill[SYNC_STAGES-1];
  assign rise        = sync_bit & ~prev;
  assign fall        = ~sync_bit & prev;
  assign timeout_hit = (cnt == TIMEOUT_VAL);

  // Synchronizer chain, edge register and chain-fill tracker
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_chain <= '0;
      fill       <= '0;
      prev       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_signal};
      fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev       <= sync_bit;
    end
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; disable overrides everything, rise beats timeout
  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (primed && !sync_bit) state_next = ARM;
        ARM:     if (rise) state_next = MEASURE;
        MEASURE: if (!rise && timeout_hit) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Period counter, fall capture and registered result outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt         <= '0;
      fall_cap    <= '0;
      o_period    <= '0;
      o_high_time <= '0;
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_enable) begin
        case (state)
          ARM: begin
            if (rise) cnt <= CNT_ONE;
          end
          MEASURE: begin
            if (fall) fall_cap <= cnt;
            if (rise) begin
              o_period    <= cnt;
              o_high_time <= fall_cap;
              o_valid     <= 1'b1;
              o_timeout   <= 1'b0;
              cnt         <= CNT_ONE;
            end else if (timeout_hit) begin
              o_timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
